reg_file_renamed: RTL and testbench
===================================

# reg_file_renamed

Parametrised architectural register file with per-register rename tracking for the Tomasulo core. It sits between the reservation stations, which read operands and claim destinations at issue, and the ROB, which writes committed results. It returns either a ready value or the ROB tag that will produce the operand. It adds configurable data width, register count, ROB tag width, and mispredict flush over the previous register file.

## Interface

Parameters:
- XLEN, 32, data width
- NREG, 32, architectural register count (power of two, ≥2); RAW = log2(NREG)
- ROB_WIDTH, 3, ROB tag width
- RS_WIDTH, 2, reservation-station index width

Ports:
- clk_in  input  1  clock; one clock, all state on rising edge
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global enable; low = stall
- from_rs_valid  input  1  issue request strobe
- from_rs_index  input  RS_WIDTH  requesting RS entry
- from_rs_rs1 / from_rs_rs2  input  RAW  source register numbers
- from_rs_rd_valid  input  1  instruction writes rd
- from_rs_rd  input  RAW  destination register
- from_rs_rob_tag  input  ROB_WIDTH  ROB entry allocated to this instruction
- from_rob  input  1  commit strobe
- from_rob_rd  input  RAW  commit destination
- from_rob_tag  input  ROB_WIDTH  committing ROB entry
- from_rob_wdata  input  XLEN  commit data
- flush_in  input  1  mispredict flush
- to_rs_valid  output  1  response strobe
- to_rs_index  output  RS_WIDTH  echoed from_rs_index
- to_rs_rs1 / to_rs_rs2  output  XLEN  operand value (valid when busy=0)
- to_rs_rs1_busy / to_rs_rs2_busy  output  1  operand pending
- to_rs_rs1_tag / to_rs_rs2_tag  output  ROB_WIDTH  producing ROB tag (valid when busy=1)

## Operation

- State per register: data[XLEN], busy, tag[ROB_WIDTH].
- Register 0: reads data 0, busy 0, tag 0; writes and renames to x0 are ignored.
- Request (from_rs_valid=1): sources are read from the pre-rename state, so rs1==rd returns the old mapping. Then, if from_rs_rd_valid and rd≠0, set busy[rd]=1 and tag[rd]=from_rs_rob_tag.
- Commit (from_rob=1, rd≠0): data[rd] is always written. busy[rd] is cleared only if tag[rd]==from_rob_tag. A stale tag means a younger writer still owns rd.
- Same cycle, same rd, rename and commit: data is written, and the rename wins (busy=1, new tag).
- flush_in=1: clear all busy bits and ignore any rename that cycle. A same-cycle commit still writes data. to_rs_valid=0 in the following cycle.
- rdy_in=0: all architectural state holds, requests and commits are ignored, and to_rs_valid is registered 0. Other outputs hold.
- rst_in=1: takes effect on the clock edge regardless of rdy_in or other inputs. All data, busy, and tag bits are 0. All outputs are 0.

## Timing

- Response latency is 1 cycle. A request at edge N gives to_rs_valid=1 with all operand fields during cycle N+1, for exactly one cycle per request.
- Back-to-back requests are accepted every cycle. There is no backpressure.
- A rename at edge N is visible to a request sampled at edge N+1.
- A commit at edge N is visible to a request at edge N+1. For a request at edge N itself, see Configuration.
- Reset asserted mid-stream: the response of an in-flight request is dropped, so to_rs_valid=0 on the next cycle.

## Configuration

- REGFILE_BYPASS_EN defined: a request in the same cycle as a commit sees the commit's effect.
  - If the source equals from_rob_rd (≠0) and its current tag equals from_rob_tag, the response is busy=0 with value from_rob_wdata.
  - If the tags do not match, the response is busy=1 with the current tag, and the value is from_rob_wdata.
- REGFILE_BYPASS_EN undefined: the response reflects pre-commit state (busy=1, old tag). The consuming RS must snoop the ROB broadcast in the response cycle. No combinational path runs from the from_rob_* inputs to the response registers.

## Test plan

- Reset then request rs1=5, rs2=0 → next cycle to_rs_valid=1, both values 0, both busy 0.
- Rename x5 with tag 3, next cycle request rs1=5 → busy=1, tag=3. Commit x5 tag 3 with 0xDEADBEEF, next cycle request → busy=0, value 0xDEADBEEF.
- Rename x7 to tag 2, then rename x7 to tag 4, then commit x7 tag 2 with data 0x11 → data=0x11 but busy stays 1 with tag 4. Commit tag 4 → busy clears.
- Request rs1=rd=9, rd_valid=1, tag 1, with x9 idle → response busy=0 (old mapping). A following request → busy=1, tag=1.
- Rename x3 and x4, then assert flush_in with a concurrent rename of x6 → next cycle to_rs_valid=0. Later reads of x3, x4, x6 all return busy=0.
- Same-cycle commit x5 tag 3 (data 0x55) and request rs1=5 → with REGFILE_BYPASS_EN: busy=0, value 0x55. Without it: busy=1, tag=3.

Source files
------------

// File: rtl/reg_file_renamed_if.sv
// Issue/commit bus between the reservation stations, the ROB and the renamed register file.
// The register file takes the slave modport; the RS/ROB side (or a bench) takes master.
interface reg_file_renamed_if #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int ROB_WIDTH = 3,
    parameter int RS_WIDTH  = 2
);
    localparam int RAW = $clog2(NREG);

    logic                 rdy_in;
    logic                 flush_in;
    logic                 from_rs_valid;
    logic [RS_WIDTH-1:0]  from_rs_index;
    logic [RAW-1:0]       from_rs_rs1;
    logic [RAW-1:0]       from_rs_rs2;
    logic                 from_rs_rd_valid;
    logic [RAW-1:0]       from_rs_rd;
    logic [ROB_WIDTH-1:0] from_rs_rob_tag;
    logic                 from_rob;
    logic [RAW-1:0]       from_rob_rd;
    logic [ROB_WIDTH-1:0] from_rob_tag;
    logic [XLEN-1:0]      from_rob_wdata;
    logic                 to_rs_valid;
    logic [RS_WIDTH-1:0]  to_rs_index;
    logic [XLEN-1:0]      to_rs_rs1;
    logic [XLEN-1:0]      to_rs_rs2;
    logic                 to_rs_rs1_busy;
    logic                 to_rs_rs2_busy;
    logic [ROB_WIDTH-1:0] to_rs_rs1_tag;
    logic [ROB_WIDTH-1:0] to_rs_rs2_tag;

    modport master (
        output rdy_in, flush_in,
        output from_rs_valid, from_rs_index, from_rs_rs1, from_rs_rs2,
        output from_rs_rd_valid, from_rs_rd, from_rs_rob_tag,
        output from_rob, from_rob_rd, from_rob_tag, from_rob_wdata,
        input  to_rs_valid, to_rs_index, to_rs_rs1, to_rs_rs2,
        input  to_rs_rs1_busy, to_rs_rs2_busy, to_rs_rs1_tag, to_rs_rs2_tag
    );

    modport slave (
        input  rdy_in, flush_in,
        input  from_rs_valid, from_rs_index, from_rs_rs1, from_rs_rs2,
        input  from_rs_rd_valid, from_rs_rd, from_rs_rob_tag,
        input  from_rob, from_rob_rd, from_rob_tag, from_rob_wdata,
        output to_rs_valid, to_rs_index, to_rs_rs1, to_rs_rs2,
        output to_rs_rs1_busy, to_rs_rs2_busy, to_rs_rs1_tag, to_rs_rs2_tag
    );
endinterface

// File: rtl/reg_file_renamed.sv
// Architectural register file with per-register rename (busy/tag) tracking and mispredict flush.
// Optional macro REGFILE_BYPASS_EN: a same-cycle commit is forwarded into the operand response.
module reg_file_renamed #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int ROB_WIDTH = 3,
    parameter int RS_WIDTH  = 2
) (
    input logic               clk_in,
    input logic               rst_in,
    reg_file_renamed_if.slave bus
);
    localparam int RAW = $clog2(NREG);

    logic [XLEN-1:0]      data_q [NREG];
    logic [ROB_WIDTH-1:0] tag_q  [NREG];
    logic [NREG-1:0]      busy_q;

    logic [RAW-1:0]       src     [2];
    logic [XLEN-1:0]      rd_val  [2];
    logic                 rd_busy [2];
    logic [ROB_WIDTH-1:0] rd_tag  [2];

    logic accept;
    assign accept = bus.from_rs_valid && !bus.flush_in;

    assign src[0] = bus.from_rs_rs1;
    assign src[1] = bus.from_rs_rs2;

    // Operand lookup against pre-rename state; x0 is hardwired to an idle zero.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p]  = data_q[src[p]];
            rd_busy[p] = busy_q[src[p]];
            rd_tag[p]  = tag_q[src[p]];
`ifdef REGFILE_BYPASS_EN
            if (bus.from_rob && bus.from_rob_rd == src[p]) begin
                rd_val[p] = bus.from_rob_wdata;
                if (tag_q[src[p]] == bus.from_rob_tag)
                    rd_busy[p] = 1'b0;
            end
`endif
            if (src[p] == '0) begin
                rd_val[p]  = '0;
                rd_busy[p] = 1'b0;
                rd_tag[p]  = '0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q             <= '0;
            bus.to_rs_valid    <= 1'b0;
            bus.to_rs_index    <= '0;
            bus.to_rs_rs1      <= '0;
            bus.to_rs_rs2      <= '0;
            bus.to_rs_rs1_busy <= 1'b0;
            bus.to_rs_rs2_busy <= 1'b0;
            bus.to_rs_rs1_tag  <= '0;
            bus.to_rs_rs2_tag  <= '0;
        end else if (bus.rdy_in) begin
            bus.to_rs_valid <= accept;
            if (accept) begin
                bus.to_rs_index    <= bus.from_rs_index;
                bus.to_rs_rs1      <= rd_val[0];
                bus.to_rs_rs2      <= rd_val[1];
                bus.to_rs_rs1_busy <= rd_busy[0];
                bus.to_rs_rs2_busy <= rd_busy[1];
                bus.to_rs_rs1_tag  <= rd_tag[0];
                bus.to_rs_rs2_tag  <= rd_tag[1];
            end
            // A stale commit tag means a younger writer still owns rd, so busy stays set.
            if (bus.from_rob && bus.from_rob_rd != '0) begin
                data_q[bus.from_rob_rd] <= bus.from_rob_wdata;
                if (tag_q[bus.from_rob_rd] == bus.from_rob_tag)
                    busy_q[bus.from_rob_rd] <= 1'b0;
            end
            // Later assignments win: a same-cycle rename overrides the commit's busy clear.
            if (bus.flush_in) begin
                busy_q <= '0;
            end else if (bus.from_rs_valid && bus.from_rs_rd_valid && bus.from_rs_rd != '0) begin
                busy_q[bus.from_rs_rd] <= 1'b1;
                tag_q[bus.from_rs_rd]  <= bus.from_rs_rob_tag;
            end
        end else begin
            bus.to_rs_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_file_renamed.sv
// Directed-vector bench for reg_file_renamed: rename, commit, stale commit, flush, stall, reset.
module tb_reg_file_renamed;
    logic clk_in = 1'b0;
    logic rst_in;
    int   n_vec = 0;
    int   n_err = 0;
    logic [1:0] idx = 2'd0;
    bit   bypass;

    reg_file_renamed_if bus ();
    reg_file_renamed dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_strobes();
        bus.from_rs_valid    = 1'b0;
        bus.from_rs_rd_valid = 1'b0;
        bus.from_rob         = 1'b0;
        bus.flush_in         = 1'b0;
    endtask

    task automatic req(input logic [4:0] rs1, input logic [4:0] rs2, input logic rdv,
                       input logic [4:0] rd, input logic [2:0] tag);
        idx                  = idx + 2'd1;
        bus.from_rs_valid    = 1'b1;
        bus.from_rs_index    = idx;
        bus.from_rs_rs1      = rs1;
        bus.from_rs_rs2      = rs2;
        bus.from_rs_rd_valid = rdv;
        bus.from_rs_rd       = rd;
        bus.from_rs_rob_tag  = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [2:0] tag, input logic [31:0] data);
        bus.from_rob       = 1'b1;
        bus.from_rob_rd    = rd;
        bus.from_rob_tag   = tag;
        bus.from_rob_wdata = data;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        clear_strobes();
    endtask

    initial begin
`ifdef REGFILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        clear_strobes();
        bus.rdy_in = 1'b1;
        bus.from_rs_index = '0; bus.from_rs_rs1 = '0; bus.from_rs_rs2 = '0;
        bus.from_rs_rd = '0; bus.from_rs_rob_tag = '0;
        bus.from_rob_rd = '0; bus.from_rob_tag = '0; bus.from_rob_wdata = '0;
        rst_in = 1'b1;
        tick(); tick();
        chk("rst_valid", {31'd0, bus.to_rs_valid}, 32'd0);
        chk("rst_rs1",   bus.to_rs_rs1, 32'd0);
        chk("rst_busy",  {30'd0, bus.to_rs_rs1_busy, bus.to_rs_rs2_busy}, 32'd0);
        rst_in = 1'b0;

        req(5'd5, 5'd0, 1'b0, 5'd0, 3'd0); tick();
        chk("first_valid", {31'd0, bus.to_rs_valid}, 32'd1);
        chk("first_index", {30'd0, bus.to_rs_index}, {30'd0, idx});
        chk("first_vals",  bus.to_rs_rs1 | bus.to_rs_rs2, 32'd0);
        chk("first_busy",  {30'd0, bus.to_rs_rs1_busy, bus.to_rs_rs2_busy}, 32'd0);
        tick();
        chk("one_shot_valid", {31'd0, bus.to_rs_valid}, 32'd0);

        req(5'd0, 5'd0, 1'b1, 5'd5, 3'd3); tick();
        req(5'd5, 5'd0, 1'b0, 5'd0, 3'd0); tick();
        chk("x5_busy", {31'd0, bus.to_rs_rs1_busy}, 32'd1);
        chk("x5_tag",  {29'd0, bus.to_rs_rs1_tag}, 32'd3);
        commit(5'd5, 3'd3, 32'hDEADBEEF); tick();
        req(5'd5, 5'd0, 1'b0, 5'd0, 3'd0); tick();
        chk("x5_commit_busy", {31'd0, bus.to_rs_rs1_busy}, 32'd0);
        chk("x5_commit_val",  bus.to_rs_rs1, 32'hDEADBEEF);

        req(5'd0, 5'd0, 1'b1, 5'd7, 3'd2); tick();
        req(5'd0, 5'd0, 1'b1, 5'd7, 3'd4); tick();
        commit(5'd7, 3'd2, 32'h11); tick();
        req(5'd0, 5'd7, 1'b0, 5'd0, 3'd0); tick();
        chk("x7_stale_busy", {31'd0, bus.to_rs_rs2_busy}, 32'd1);
        chk("x7_stale_tag",  {29'd0, bus.to_rs_rs2_tag}, 32'd4);
        chk("x7_stale_val",  bus.to_rs_rs2, 32'h11);
        commit(5'd7, 3'd4, 32'h22); tick();
        req(5'd7, 5'd7, 1'b0, 5'd0, 3'd0); tick();
        chk("x7_clear_busy", {30'd0, bus.to_rs_rs1_busy, bus.to_rs_rs2_busy}, 32'd0);
        chk("x7_clear_val",  bus.to_rs_rs2, 32'h22);

        req(5'd9, 5'd0, 1'b1, 5'd9, 3'd1); tick();
        chk("x9_old_busy", {31'd0, bus.to_rs_rs1_busy}, 32'd0);
        req(5'd9, 5'd0, 1'b0, 5'd0, 3'd0); tick();
        chk("x9_new_busy", {31'd0, bus.to_rs_rs1_busy}, 32'd1);
        chk("x9_new_tag",  {29'd0, bus.to_rs_rs1_tag}, 32'd1);

        req(5'd0, 5'd0, 1'b1, 5'd3, 3'd5); tick();
        req(5'd0, 5'd0, 1'b1, 5'd4, 3'd6); tick();
        req(5'd3, 5'd4, 1'b1, 5'd6, 3'd7); bus.flush_in = 1'b1; tick();
        chk("flush_valid", {31'd0, bus.to_rs_valid}, 32'd0);
        req(5'd3, 5'd4, 1'b0, 5'd0, 3'd0); tick();
        chk("flush_x3x4", {30'd0, bus.to_rs_rs1_busy, bus.to_rs_rs2_busy}, 32'd0);
        req(5'd6, 5'd9, 1'b0, 5'd0, 3'd0); tick();
        chk("flush_x6x9", {30'd0, bus.to_rs_rs1_busy, bus.to_rs_rs2_busy}, 32'd0);

        req(5'd0, 5'd0, 1'b1, 5'd5, 3'd3); tick();
        commit(5'd5, 3'd3, 32'h55); req(5'd5, 5'd0, 1'b0, 5'd0, 3'd0); tick();
        chk("same_cyc_busy", {31'd0, bus.to_rs_rs1_busy}, bypass ? 32'd0 : 32'd1);
        chk("same_cyc_field", bypass ? bus.to_rs_rs1 : {29'd0, bus.to_rs_rs1_tag},
            bypass ? 32'h55 : 32'd3);
        req(5'd5, 5'd0, 1'b0, 5'd0, 3'd0); tick();
        chk("after_cyc_val", bus.to_rs_rs1, 32'h55);
        chk("after_cyc_busy", {31'd0, bus.to_rs_rs1_busy}, 32'd0);

        bus.rdy_in = 1'b0;
        req(5'd10, 5'd0, 1'b1, 5'd10, 3'd2); commit(5'd11, 3'd0, 32'h99); tick();
        chk("stall_valid", {31'd0, bus.to_rs_valid}, 32'd0);
        chk("stall_hold",  bus.to_rs_rs1, 32'h55);
        bus.rdy_in = 1'b1;
        req(5'd10, 5'd11, 1'b0, 5'd0, 3'd0); tick();
        chk("stall_no_rename", {31'd0, bus.to_rs_rs1_busy}, 32'd0);
        chk("stall_no_commit", bus.to_rs_rs2, 32'd0);

        req(5'd0, 5'd0, 1'b1, 5'd8, 3'd1); tick();
        commit(5'd8, 3'd1, 32'h77); req(5'd0, 5'd0, 1'b1, 5'd8, 3'd5); tick();
        req(5'd8, 5'd0, 1'b0, 5'd0, 3'd0); tick();
        chk("ren_wins_busy", {31'd0, bus.to_rs_rs1_busy}, 32'd1);
        chk("ren_wins_tag",  {29'd0, bus.to_rs_rs1_tag}, 32'd5);
        chk("ren_wins_data", bus.to_rs_rs1, 32'h77);

        commit(5'd0, 3'd0, 32'hFF); req(5'd0, 5'd0, 1'b1, 5'd0, 3'd6); tick();
        req(5'd1, 5'd0, 1'b0, 5'd0, 3'd0); tick();
        chk("x0_val",  bus.to_rs_rs2, 32'd0);
        chk("x0_busy", {31'd0, bus.to_rs_rs2_busy}, 32'd0);

        req(5'd5, 5'd0, 1'b0, 5'd0, 3'd0); rst_in = 1'b1; tick();
        chk("midrst_valid", {31'd0, bus.to_rs_valid}, 32'd0);
        rst_in = 1'b0;
        req(5'd5, 5'd8, 1'b0, 5'd0, 3'd0); tick();
        chk("midrst_x5", bus.to_rs_rs1, 32'd0);
        chk("midrst_x8_busy", {31'd0, bus.to_rs_rs2_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
